// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with per-entry saturating counters plus resolve-side mispredict/redirect check.
// Optional statistics counters are enabled by defining BRANCH_PREDICT_STATS_EN.
module branch_predict_unit #(
  parameter int AddressWidth = 10,
  parameter int Entries      = 16,
  parameter int CounterWidth = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [AddressWidth-1:0] fetch_pc_i,
  output logic                    pred_taken_o,
  output logic [AddressWidth-1:0] pred_target_o,
  input  logic                    resolve_valid_i,
  input  logic [AddressWidth-1:0] resolve_pc_i,
  input  logic                    resolve_jal_i,
  input  logic                    resolve_jalr_i,
  input  logic                    resolve_branch_i,
  input  logic                    resolve_taken_i,
  input  logic [AddressWidth-1:0] resolve_target_i,
  input  logic                    resolve_pred_taken_i,
  input  logic [AddressWidth-1:0] resolve_pred_target_i,
  output logic                    mispredict_o,
  output logic [AddressWidth-1:0] redirect_pc_o
`ifdef BRANCH_PREDICT_STATS_EN
  ,
  output logic [31:0]             stat_resolved_o,
  output logic [31:0]             stat_mispredict_o
`endif
);

  localparam int IdxW = $clog2(Entries);
  localparam int TagW = AddressWidth - 2 - IdxW;
  localparam logic [CounterWidth-1:0] CntMax  = '1;
  localparam logic [CounterWidth-1:0] CntInit = CounterWidth'(1) << (CounterWidth - 1);

  logic [Entries-1:0]      r_valid;
  logic [TagW-1:0]         r_tag     [Entries];
  logic [AddressWidth-1:0] r_target  [Entries];
  logic [CounterWidth-1:0] r_counter [Entries];

  logic [IdxW-1:0]         w_fetchIdx;
  logic [TagW-1:0]         w_fetchTag;
  logic                    w_fetchHit;
  logic [IdxW-1:0]         w_resIdx;
  logic [TagW-1:0]         w_resTag;
  logic                    w_resHit;
  logic                    w_actTaken;
  logic                    w_mispredict;
  logic [CounterWidth-1:0] w_cntCur;
  logic [CounterWidth-1:0] w_cntInc;
  logic [CounterWidth-1:0] w_cntDec;
  logic                    w_setValid;
  logic                    w_clrValid;
  logic                    w_cntWe;
  logic [CounterWidth-1:0] w_cntNext;
  logic                    w_entryWe;
  logic                    w_unused;

  // Word-aligned PCs: the two low bits never index or tag the table.
  assign w_unused = ^fetch_pc_i[1:0];

  assign w_fetchIdx = fetch_pc_i[2+IdxW-1:2];
  assign w_fetchTag = fetch_pc_i[AddressWidth-1:2+IdxW];
  assign w_fetchHit = r_valid[w_fetchIdx] && (r_tag[w_fetchIdx] == w_fetchTag);

  assign pred_taken_o  = w_fetchHit & r_counter[w_fetchIdx][CounterWidth-1];
  assign pred_target_o = pred_taken_o ? r_target[w_fetchIdx] : '0;

  assign w_resIdx = resolve_pc_i[2+IdxW-1:2];
  assign w_resTag = resolve_pc_i[AddressWidth-1:2+IdxW];
  assign w_resHit = r_valid[w_resIdx] && (r_tag[w_resIdx] == w_resTag);

  assign w_actTaken   = resolve_jal_i | resolve_jalr_i | (resolve_branch_i & resolve_taken_i);
  assign w_mispredict = resolve_valid_i &
                        ((w_actTaken != resolve_pred_taken_i) |
                         (w_actTaken & (resolve_target_i != resolve_pred_target_i)));

  assign mispredict_o  = w_mispredict;
  assign redirect_pc_o = !w_mispredict ? '0 :
                         w_actTaken    ? resolve_target_i :
                                         resolve_pc_i + AddressWidth'(4);

  assign w_cntCur = r_counter[w_resIdx];
  assign w_cntInc = (w_cntCur == CntMax) ? CntMax : w_cntCur + CounterWidth'(1);
  assign w_cntDec = (w_cntCur == '0) ? '0 : w_cntCur - CounterWidth'(1);

  // Decide what the resolving instruction does to its table entry this edge.
  always_comb begin
    w_setValid = 1'b0;
    w_clrValid = 1'b0;
    w_cntWe    = 1'b0;
    w_cntNext  = w_cntCur;
    w_entryWe  = 1'b0;
    if (resolve_valid_i) begin
      if (resolve_jal_i) begin
        w_setValid = 1'b1;
        w_entryWe  = 1'b1;
        w_cntWe    = 1'b1;
        w_cntNext  = CntMax;
      end else if (resolve_jalr_i) begin
        w_clrValid = w_resHit;
      end else if (resolve_branch_i) begin
        if (w_resHit) begin
          w_cntWe   = 1'b1;
          w_cntNext = resolve_taken_i ? w_cntInc : w_cntDec;
          w_entryWe = resolve_taken_i;
        end else if (resolve_taken_i) begin
          w_setValid = 1'b1;
          w_entryWe  = 1'b1;
          w_cntWe    = 1'b1;
          w_cntNext  = CntInit;
        end
      end else begin
        // A hit on something that is no longer a control-flow instruction is stale.
        w_clrValid = w_resHit;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      for (int i = 0; i < Entries; i++) begin
        r_counter[i] <= '0;
      end
    end else begin
      if (w_setValid) begin
        r_valid[w_resIdx] <= 1'b1;
      end else if (w_clrValid) begin
        r_valid[w_resIdx] <= 1'b0;
      end
      if (w_cntWe) begin
        r_counter[w_resIdx] <= w_cntNext;
      end
    end
  end

  // Tags and targets are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_entryWe) begin
      r_tag[w_resIdx]    <= w_resTag;
      r_target[w_resIdx] <= resolve_target_i;
    end
  end

`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] r_statResolved;
  logic [31:0] r_statMispredict;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_statResolved   <= '0;
      r_statMispredict <= '0;
    end else begin
      if (resolve_valid_i) begin
        r_statResolved <= r_statResolved + 32'd1;
      end
      if (w_mispredict) begin
        r_statMispredict <= r_statMispredict + 32'd1;
      end
    end
  end

  assign stat_resolved_o   = r_statResolved;
  assign stat_mispredict_o = r_statMispredict;
`endif

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the fetch/branch target logic. It predicts direction and target for the fetch PC from a direct-mapped branch target buffer (BTB) with per-entry saturating counters. It also checks each resolved control-flow instruction against its prediction and emits a redirect on mispredict. It sits between the PC register (lookup side) and the execute-stage branch resolution (update side). Its prediction feeds the next-PC mux, and its redirect overrides that prediction.

## Interface
- AddressWidth, 10: PC width in bits (byte address, word-aligned).
- Entries, 16: BTB/counter entries; power of two, ≥2; IdxW = log2(Entries).
- CounterWidth, 2: saturating counter width, ≥1.
- Constraint: AddressWidth > 2+IdxW. TagW = AddressWidth-2-IdxW.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- fetch_pc_i  in  AddressWidth  PC being fetched.
- pred_taken_o  out  1  predicted taken for fetch_pc_i.
- pred_target_o  out  AddressWidth  predicted target; 0 when pred_taken_o=0.
- resolve_valid_i  in  1  a resolved instruction is presented this cycle.
- resolve_pc_i  in  AddressWidth  PC of resolved instruction.
- resolve_jal_i / resolve_jalr_i / resolve_branch_i  in  1 each  instruction class (at most one set).
- resolve_taken_i  in  1  branch condition (ALU flag); ignored for jal/jalr.
- resolve_target_i  in  AddressWidth  computed target (pc+imm, or rs1+imm for jalr).
- resolve_pred_taken_i  in  1  prediction made at fetch for this instruction.
- resolve_pred_target_i  in  AddressWidth  target predicted at fetch.
- mispredict_o  out  1  redirect required.
- redirect_pc_o  out  AddressWidth  correct next PC; 0 when mispredict_o=0.

## Operation
- Index = pc[2+IdxW-1:2]; tag = pc[AddressWidth-1:2+IdxW]. Each entry holds valid, tag, target, counter.
- Lookup is combinational. Hit = valid[idx] & tag match. pred_taken_o = hit & counter MSB. pred_target_o = stored target when pred_taken_o, else 0.
- Actual taken (act) = jal | jalr | (branch & resolve_taken_i).
- mispredict_o = resolve_valid_i & ((act != resolve_pred_taken_i) | (act & resolve_target_i != resolve_pred_target_i)).
- redirect_pc_o = act ? resolve_target_i : resolve_pc_i+4 (mod 2^AddressWidth), gated by mispredict_o.
- Update on the edge, when resolve_valid_i and not rst_i:
  - branch, hit: counter +1 if taken (saturate at 2^CW-1), -1 if not (saturate at 0); target overwritten when taken.
  - branch, miss, taken: allocate (valid=1, tag, target, counter=2^(CW-1)), replacing any occupant.
  - branch, miss, not taken: no change.
  - jal: allocate/overwrite with counter=2^CW-1.
  - jalr: never allocated. A hit entry at that index/tag is invalidated.
  - No class flag set, entry hit: invalidate (stale entry). Such an instruction with resolve_pred_taken_i=1 mispredicts to pc+4.

## Timing
- Lookup and mispredict/redirect: zero-cycle combinational.
- Table update is visible to lookups from the cycle after the resolving edge.
- Same-index lookup and update in one cycle: the lookup sees pre-edge contents.
- Reset: all valid bits and counters cleared in one cycle. Tags and targets are don't-care. Outputs read pred_taken_o=0, pred_target_o=0; mispredict_o follows inputs combinationally.
- rst_i asserted with resolve_valid_i: reset wins, no update.

## Configuration
- BRANCH_PREDICT_STATS_EN defined adds:
  - Outputs stat_resolved_o[31:0] and stat_mispredict_o[31:0].
  - Each increments on every resolve_valid_i / mispredict_o cycle, wraps at 2^32, and is cleared by rst_i.
- Undefined: ports and counters are absent. Predictor behaviour is identical either way.

## Test plan
- After reset, fetch_pc_i=0x040 -> pred_taken_o=0, pred_target_o=0.
- Resolve branch pc=0x040 taken, target=0x080, pred_taken=0 -> mispredict_o=1, redirect 0x080. Next cycle, fetch 0x040 -> pred_taken_o=1 (counter 2), target 0x080.
- Two not-taken resolves at 0x040 -> counter 2->1->0. Fetch gives pred_taken_o=0. Third not-taken holds 0. Four taken resolves saturate at 3.
- Alias: resolve jal pc=0x140 (same index as 0x040 at Entries=16, different tag) -> entry replaced. Fetch 0x040 misses, 0x140 hits with counter 3.
- Resolve jalr pc=0x3FC, pred_taken=0, target=0x010 -> mispredict, redirect 0x010, no allocation. Not-taken branch at 0x3FC predicted taken -> redirect 0x000 (wrap).
- With BRANCH_PREDICT_STATS_EN: 5 resolves, 2 mispredicts -> stat_resolved_o=5, stat_mispredict_o=2. rst_i -> both 0.
